// File: rtl/add_share_pkg.sv
// ---------------------------------------------------------------------------
// add_share_pkg
// Shared definitions for the time-shared approximate adder block.
//
// Contents:
//   ADD_SHARE_NUM_REQ / ADD_SHARE_DATA_W : default requester count and
//                                          operand width
//   ADD_SHARE_ID_W                       : width of a requester index
//   APPROX_LOW_W / APPROX_BIAS           : shape of the approximate core
//   id_t                                 : requester index type
//   stage_t                              : pipeline stage record
//                                          (valid, a, b, id, exact)
//   nextId()                             : round-robin pointer successor
//
// The stage record is sized from the package defaults, so a different
// requester count or operand width is configured here, and the module
// parameters of add_share_arb are kept equal to these values.
// ---------------------------------------------------------------------------
package add_share_pkg;

    localparam int ADD_SHARE_NUM_REQ = 4;
    localparam int ADD_SHARE_DATA_W  = 8;
    localparam int ADD_SHARE_ID_W    = (ADD_SHARE_NUM_REQ > 1) ? $clog2(ADD_SHARE_NUM_REQ) : 1;

    // The approximate core adds the upper bits exactly and replaces the
    // lower APPROX_LOW_W bits (and the carry they would produce) with a
    // carry-free OR, XORed with a fixed bias that recentres the error.
    localparam int                      APPROX_LOW_W = 6;
    localparam logic [APPROX_LOW_W-1:0] APPROX_BIAS  = 6'h25;

    typedef logic [ADD_SHARE_ID_W-1:0] id_t;

    typedef struct packed {
        logic                        valid;
        logic [ADD_SHARE_DATA_W-1:0] a;
        logic [ADD_SHARE_DATA_W-1:0] b;
        id_t                         id;
        logic                        exact;
    } stage_t;

    // Successor of a requester index, wrapping after the last requester.
    function automatic id_t nextId(input id_t cur, input int numReq);
        id_t last;
        last = id_t'(numReq - 1);
        if (cur == last) begin
            return '0;
        end
        return id_t'(cur + 1'b1);
    endfunction

endpackage

// File: rtl/add_share_core.sv
// ---------------------------------------------------------------------------
// add_share_core
// Purely combinational approximate unsigned adder.
//
// Ports:
//   i_a   [DATA_W-1:0] : operand A
//   i_b   [DATA_W-1:0] : operand B
//   o_sum [DATA_W:0]   : approximate A+B
//
// The upper DATA_W-APPROX_LOW_W bits are added exactly with no carry in;
// the lower bits are (A|B)^APPROX_BIAS. Example: 0xC0 + 0x40 gives 0x125.
// ---------------------------------------------------------------------------
module add_share_core
    import add_share_pkg::*;
#(
    parameter int DATA_W = ADD_SHARE_DATA_W
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W:0]   o_sum
);

    localparam int HI_W = DATA_W - APPROX_LOW_W;

    logic [HI_W:0]         w_hiSum;
    logic [APPROX_LOW_W-1:0] w_loSum;

    // Upper part: exact add, its carry becomes the result MSB.
    assign w_hiSum = {1'b0, i_a[DATA_W-1:APPROX_LOW_W]} + {1'b0, i_b[DATA_W-1:APPROX_LOW_W]};

    // Lower part: no carry chain at all, and no carry into the upper part.
    assign w_loSum = (i_a[APPROX_LOW_W-1:0] | i_b[APPROX_LOW_W-1:0]) ^ APPROX_BIAS;

    assign o_sum = {w_hiSum, w_loSum};

endmodule

// File: rtl/add_share_arb.sv
// ---------------------------------------------------------------------------
// add_share_arb
// Round-robin arbiter sharing one approximate adder core between NUM_REQ
// requesters through a two-stage pipeline (S1 operands, S2 result).
// Latency 2 edges from accept to res_valid, throughput one result per cycle.
//
// Ports:
//   clk                         : rising-edge clock
//   rst                         : synchronous active-high reset
//   req_valid [NUM_REQ]         : per-requester request valid
//   req_a/req_b [NUM_REQ*DATA_W]: packed operands, requester i uses slice i
//   req_exact [NUM_REQ]         : (ADD_SHARE_EXACT_EN only) exact add request
//   req_ready [NUM_REQ]         : one-hot grant / accept
//   res_valid, res_ready        : result handshake
//   res_sum [DATA_W+1]          : sum
//   res_id                      : owner of the result
//   res_exact                   : (ADD_SHARE_EXACT_EN only) result is exact
//   busy                        : any pipeline stage occupied
//   ops_count [16]              : completed results, saturating
//
// Optional feature macro: ADD_SHARE_EXACT_EN adds the per-request exact path.
// ---------------------------------------------------------------------------
module add_share_arb
    import add_share_pkg::*;
#(
    parameter int NUM_REQ = ADD_SHARE_NUM_REQ,
    parameter int DATA_W  = ADD_SHARE_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
`ifdef ADD_SHARE_EXACT_EN
    input  logic [NUM_REQ-1:0]        req_exact,
    output logic                      res_exact,
`endif
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [DATA_W:0]           res_sum,
    output id_t                       res_id,
    output logic                      busy,
    output logic [15:0]               ops_count
);

    stage_t          r_s1;
    id_t             r_ptr;
    logic            r_s2Valid;
    logic [DATA_W:0] r_s2Sum;
    id_t             r_s2Id;
    logic            r_s2Exact;
    logic [15:0]     r_opsCount;

    id_t             w_grantId;
    logic            w_s2Advance;
    logic            w_s1Free;
    logic            w_accept;
    logic [DATA_W:0] w_approxSum;
    logic [DATA_W:0] w_stageSum;

    // Round-robin scan starting at the pointer. Walking the offsets from
    // the far end down lets the nearest valid requester win. With nothing
    // valid the grant stays on the pointer (lookahead ready).
    always_comb begin
        w_grantId = r_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(r_ptr) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                w_grantId = id_t'(idx);
            end
        end
    end

    // S2 can take data when empty or when its result leaves this cycle;
    // S1 can take a request when empty or when it moves into S2.
    assign w_s2Advance = !r_s2Valid || res_ready;
    assign w_s1Free    = !r_s1.valid || w_s2Advance;

    // Ready is gated by reset so no accept can happen on a reset edge.
    always_comb begin
        req_ready = '0;
        if (!rst && w_s1Free) begin
            req_ready[w_grantId] = 1'b1;
        end
    end

    assign w_accept = |(req_valid & req_ready);

    // Stage 1: capture the granted operands. A new accept overwrites an
    // entry that is moving to S2 in the same cycle, so there is no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1  <= '0;
            r_ptr <= '0;
        end else begin
            if (w_accept) begin
                r_s1.valid <= 1'b1;
                r_s1.a     <= req_a[w_grantId*DATA_W +: DATA_W];
                r_s1.b     <= req_b[w_grantId*DATA_W +: DATA_W];
                r_s1.id    <= w_grantId;
`ifdef ADD_SHARE_EXACT_EN
                r_s1.exact <= req_exact[w_grantId];
`else
                r_s1.exact <= 1'b0;
`endif
                r_ptr      <= nextId(w_grantId, NUM_REQ);
            end else if (w_s2Advance) begin
                r_s1.valid <= 1'b0;
            end
        end
    end

    add_share_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .i_a   (r_s1.a),
        .i_b   (r_s1.b),
        .o_sum (w_approxSum)
    );

`ifdef ADD_SHARE_EXACT_EN
    logic [DATA_W:0] w_exactSum;

    // Exact path is only selected for operations that asked for it.
    assign w_exactSum = {1'b0, r_s1.a} + {1'b0, r_s1.b};
    assign w_stageSum = r_s1.exact ? w_exactSum : w_approxSum;
    assign res_exact  = r_s2Exact;
`else
    logic w_unusedExact;

    assign w_stageSum    = w_approxSum;
    assign w_unusedExact = r_s2Exact;
`endif

    // Stage 2: result register. Frozen while the consumer stalls; data
    // fields only load alongside a valid entry so outputs stay quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2Valid <= 1'b0;
            r_s2Sum   <= '0;
            r_s2Id    <= '0;
            r_s2Exact <= 1'b0;
        end else if (w_s2Advance) begin
            r_s2Valid <= r_s1.valid;
            if (r_s1.valid) begin
                r_s2Sum   <= w_stageSum;
                r_s2Id    <= r_s1.id;
                r_s2Exact <= r_s1.exact;
            end
        end
    end

    // Completed-result counter, sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opsCount <= '0;
        end else if (r_s2Valid && res_ready && (r_opsCount != 16'hFFFF)) begin
            r_opsCount <= r_opsCount + 16'd1;
        end
    end

    assign res_valid = r_s2Valid;
    assign res_sum   = r_s2Sum;
    assign res_id    = r_s2Id;
    assign busy      = r_s1.valid | r_s2Valid;
    assign ops_count = r_opsCount;

endmodule

// File: tb/tb_add_share_arb.sv
// ---------------------------------------------------------------------------
// tb_add_share_arb
// Directed scoreboard bench for add_share_arb (4 requesters, 8-bit data).
// Stimulus pushes hand-computed results into a queue; a monitor pops and
// compares every time a result is handed over.
// Build with ADD_SHARE_EXACT_EN defined to also exercise the exact path.
//
// Approximate sums used below (upper 2 bits exact, low 6 = (a|b)^0x25):
//   0xC0+0x40 -> 0x125   0x01+0x02 -> 0x026   0x40+0x40 -> 0x0A5
//   0xFF+0xFF -> 0x19A   0x80+0x0F -> 0x0AA   0x00+0x00 -> 0x025
// ---------------------------------------------------------------------------
module tb_add_share_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready;
    logic [8:0]  res_sum;
    logic [1:0]  res_id;
    logic        busy;
    logic [15:0] ops_count;
`ifdef ADD_SHARE_EXACT_EN
    logic [3:0]  req_exact;
    logic        res_exact;
`endif

    typedef struct packed {
        logic [1:0] id;
        logic [8:0] sum;
        logic       exact;
    } exp_t;

    exp_t expQ[$];
    int   vecCount = 0;
    int   missCount = 0;
    bit   sbEnable = 1'b1;

    add_share_arb dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
`ifdef ADD_SHARE_EXACT_EN
        .req_exact (req_exact),
        .res_exact (res_exact),
`endif
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id),
        .busy      (busy),
        .ops_count (ops_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic ready);
        req_valid = valid;
        res_ready = ready;
    endtask

    task automatic setOperand(input int idx, input logic [7:0] a, input logic [7:0] b);
        req_a[idx*8 +: 8] = a;
        req_b[idx*8 +: 8] = b;
    endtask

    task automatic pushExpect(input logic [1:0] id, input logic [8:0] sum, input logic exact);
        exp_t e;
        e.id    = id;
        e.sum   = sum;
        e.exact = exact;
        expQ.push_back(e);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        nextCycle();
        nextCycle();
        rst = 1'b0;
    endtask

    // Monitor: every handshake must match the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && sbEnable && res_valid && res_ready) begin
            if (expQ.size() == 0) begin
                vecCount++;
                missCount++;
                $display("[TB] FAIL unexpected_result: got id %0d sum 0x%0h, expected none", res_id, res_sum);
            end else begin
                e = expQ.pop_front();
                checkOutput("res_id", 32'(res_id), 32'(e.id));
                checkOutput("res_sum", 32'(res_sum), 32'(e.sum));
`ifdef ADD_SHARE_EXACT_EN
                checkOutput("res_exact", 32'(res_exact), 32'(e.exact));
`endif
            end
        end
    end

    initial begin
        rst   = 1'b1;
        req_a = '0;
        req_b = '0;
`ifdef ADD_SHARE_EXACT_EN
        req_exact = '0;
`endif
        applyStimulus(4'h0, 1'b1);

        // Reset state, with requests present to prove ready is gated.
        nextCycle();
        nextCycle();
        applyStimulus(4'hF, 1'b1);
        @(negedge clk);
        checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
        checkOutput("rst_res_valid", 32'(res_valid), 32'h0);
        checkOutput("rst_res_sum", 32'(res_sum), 32'h0);
        checkOutput("rst_res_id", 32'(res_id), 32'h0);
        checkOutput("rst_ops_count", 32'(ops_count), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);

        // Reset mid-flight: accept requester 2, then reset on the next edge.
        nextCycle();
        rst = 1'b0;
        setOperand(2, 8'h11, 8'h22);
        applyStimulus(4'b0100, 1'b1);
        @(negedge clk);
        checkOutput("midrst_grant", 32'(req_ready), 32'b0100);
        nextCycle();
        rst = 1'b1;
        applyStimulus(4'h0, 1'b1);
        @(negedge clk);
        checkOutput("midrst_busy", 32'(busy), 32'h1);
        nextCycle();
        nextCycle();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("midrst_res_valid", 32'(res_valid), 32'h0);
            nextCycle();
        end
        @(negedge clk);
        checkOutput("midrst_ops_count", 32'(ops_count), 32'h0);
        checkOutput("midrst_ptr", 32'(req_ready), 32'b0001);

        // Single request from requester 1.
        nextCycle();
        setOperand(1, 8'hC0, 8'h40);
        pushExpect(2'd1, 9'h125, 1'b0);
        applyStimulus(4'b0010, 1'b1);
        @(negedge clk);
        checkOutput("single_grant", 32'(req_ready), 32'b0010);
        nextCycle();
        applyStimulus(4'b0000, 1'b1);
        @(negedge clk);
        checkOutput("single_lat1_valid", 32'(res_valid), 32'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("single_lat2_valid", 32'(res_valid), 32'h1);
        nextCycle();
        @(negedge clk);
        checkOutput("single_ops_count", 32'(ops_count), 32'h1);
        checkOutput("single_busy", 32'(busy), 32'h0);

`ifdef ADD_SHARE_EXACT_EN
        // Same operands routed through the exact adder.
        nextCycle();
        req_exact = 4'b0010;
        pushExpect(2'd1, 9'h100, 1'b1);
        applyStimulus(4'b0010, 1'b1);
        nextCycle();
        applyStimulus(4'b0000, 1'b1);
        req_exact = 4'b0000;
        nextCycle();
        nextCycle();
`endif

        // Fairness: all four requesting for 8 cycles from pointer 0.
        nextCycle();
        applyReset();
        setOperand(0, 8'h01, 8'h02);
        setOperand(1, 8'h40, 8'h40);
        setOperand(2, 8'hFF, 8'hFF);
        setOperand(3, 8'h80, 8'h0F);
        for (int k = 0; k < 2; k++) begin
            pushExpect(2'd0, 9'h026, 1'b0);
            pushExpect(2'd1, 9'h0A5, 1'b0);
            pushExpect(2'd2, 9'h19A, 1'b0);
            pushExpect(2'd3, 9'h0AA, 1'b0);
        end
        applyStimulus(4'hF, 1'b1);
        for (int k = 0; k < 8; k++) begin
            logic [3:0] oh;
            oh = 4'b0001 << (k % 4);
            @(negedge clk);
            checkOutput("fair_grant", 32'(req_ready), 32'(oh));
            if (k >= 2) begin
                checkOutput("fair_res_valid", 32'(res_valid), 32'h1);
            end
            nextCycle();
        end
        applyStimulus(4'h0, 1'b1);
        repeat (3) nextCycle();

        // Backpressure: consumer stalls with requests pending.
        pushExpect(2'd0, 9'h026, 1'b0);
        pushExpect(2'd1, 9'h0A5, 1'b0);
        pushExpect(2'd2, 9'h19A, 1'b0);
        pushExpect(2'd3, 9'h0AA, 1'b0);
        applyStimulus(4'hF, 1'b0);
        @(negedge clk);
        checkOutput("bp_grant0", 32'(req_ready), 32'b0001);
        nextCycle();
        @(negedge clk);
        checkOutput("bp_grant1", 32'(req_ready), 32'b0010);
        nextCycle();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("bp_stall_ready", 32'(req_ready), 32'h0);
            checkOutput("bp_stall_valid", 32'(res_valid), 32'h1);
            checkOutput("bp_stall_id", 32'(res_id), 32'h0);
            checkOutput("bp_stall_sum", 32'(res_sum), 32'h026);
            checkOutput("bp_stall_busy", 32'(busy), 32'h1);
            nextCycle();
        end
        applyStimulus(4'hF, 1'b1);
        @(negedge clk);
        checkOutput("bp_resume_grant2", 32'(req_ready), 32'b0100);
        nextCycle();
        @(negedge clk);
        checkOutput("bp_resume_grant3", 32'(req_ready), 32'b1000);
        nextCycle();
        applyStimulus(4'h0, 1'b1);
        repeat (4) nextCycle();
        checkOutput("bp_queue_empty", 32'(expQ.size()), 32'h0);

        // Saturation: preload 65534 results unchecked, then 3 more.
        applyReset();
        sbEnable = 1'b0;
        setOperand(0, 8'h00, 8'h00);
        applyStimulus(4'b0001, 1'b1);
        repeat (65534) nextCycle();
        applyStimulus(4'b0000, 1'b1);
        repeat (3) nextCycle();
        @(negedge clk);
        checkOutput("sat_preload", 32'(ops_count), 32'hFFFE);
        nextCycle();
        sbEnable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pushExpect(2'd0, 9'h025, 1'b0);
        end
        applyStimulus(4'b0001, 1'b1);
        repeat (3) nextCycle();
        applyStimulus(4'b0000, 1'b1);
        repeat (4) nextCycle();
        @(negedge clk);
        checkOutput("sat_ops_count", 32'(ops_count), 32'hFFFF);
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkOutput("sat_hold", 32'(ops_count), 32'hFFFF);
        checkOutput("final_queue_empty", 32'(expQ.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
